// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bundles the decode-side redirect/stall controls, the
//               instruction-memory port and the IF/ID pipeline outputs of
//               the fetch stage.
//                 master : the fetch unit
//                          (drives InstrAddr, pc, instr, pcPlus4 and valid)
//                 slave  : the surrounding pipeline and memory
//                          (drives the controls and InstrIn)
//               Signals:
//                 stall          hold PC and the IF/ID register this cycle
//                 branchEn       taken conditional branch resolved in decode
//                 branchImm      signed word offset of the branch
//                 jumpEn         unconditional jump resolved in decode
//                 jumpTarget     J-type 26-bit target field
//                 decodePcPlus4  PC+4 of the instruction currently in decode
//                 InstrIn        combinational memory read data for InstrAddr
//                 InstrAddr      byte address driven to instruction memory
//                 pc             current fetch PC
//                 instr          IF/ID instruction register
//                 pcPlus4        IF/ID registered PC+4 of instr
//                 valid          IF/ID holds a live instruction
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
  logic        stall;
  logic        branchEn;
  logic [15:0] branchImm;
  logic        jumpEn;
  logic [25:0] jumpTarget;
  logic [31:0] decodePcPlus4;
  logic [31:0] InstrIn;
  logic [9:0]  InstrAddr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] pcPlus4;
  logic        valid;

  modport master (
    input  stall,
    input  branchEn,
    input  branchImm,
    input  jumpEn,
    input  jumpTarget,
    input  decodePcPlus4,
    input  InstrIn,
    output InstrAddr,
    output pc,
    output instr,
    output pcPlus4,
    output valid
  );

  modport slave (
    output stall,
    output branchEn,
    output branchImm,
    output jumpEn,
    output jumpTarget,
    output decodePcPlus4,
    output InstrIn,
    input  InstrAddr,
    input  pc,
    input  instr,
    input  pcPlus4,
    input  valid
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction-fetch stage with the IF/ID pipeline register.
//               Keeps the fetch PC, addresses a combinational-read
//               instruction memory with pc[9:0], and captures the returned
//               word into IF/ID one cycle later. Jumps and taken branches
//               resolved in decode redirect the PC and squash the word
//               fetched in the same cycle, leaving a one-cycle bubble.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - instruction_fetch_if.master: controls, memory port
//                        and IF/ID outputs
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch (
  input  wire logic           clk,
  input  wire logic           rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] C_PC_STEP   = 32'd4;
  localparam logic [31:0] C_NOP       = 32'h0000_0000;
  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // --------------------------------------------------------------------------
  // Next-PC computation
  // --------------------------------------------------------------------------
  logic [31:0] w_seq_pc;
  logic [31:0] w_branch_off;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_redirect_tgt;
  logic        w_redirect;

  // Sequential PC wraps naturally at 2^32.
  assign w_seq_pc     = r_pc + C_PC_STEP;

  // Sign-extend the word offset and scale it to bytes in one concatenation.
  assign w_branch_off = {{14{bus.branchImm[15]}}, bus.branchImm, 2'b00};
  assign w_branch_tgt = bus.decodePcPlus4 + w_branch_off;

  assign w_jump_tgt   = {bus.decodePcPlus4[31:28], bus.jumpTarget, 2'b00};

  assign w_redirect   = bus.jumpEn | bus.branchEn;

  // Jump wins over branch; the low two bits are cleared so that the PC stays
  // word aligned even when decodePcPlus4 carries stray low bits.
  always_comb begin
    w_redirect_tgt = w_branch_tgt;
    if (bus.jumpEn) begin
      w_redirect_tgt = w_jump_tgt;
    end
    w_redirect_tgt = w_redirect_tgt & C_WORD_MASK;
  end

  // --------------------------------------------------------------------------
  // PC and IF/ID register
  // A redirect overrides stall: the word fetched at the old PC belongs to the
  // wrong path, so it is replaced with a NOP and marked invalid. pcPlus4 still
  // records the old PC+4 for that bubble slot.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= 32'h0000_0000;
      r_instr    <= C_NOP;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= w_redirect_tgt;
      r_instr    <= C_NOP;
      r_pc_plus4 <= w_seq_pc;
      r_valid    <= 1'b0;
    end else if (!bus.stall) begin
      r_pc       <= w_seq_pc & C_WORD_MASK;
      r_instr    <= bus.InstrIn;
      r_pc_plus4 <= w_seq_pc;
      r_valid    <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // Memory only sees the low 10 address bits; the upper PC bits are ignored.
  // --------------------------------------------------------------------------
  assign bus.InstrAddr = r_pc[9:0];
  assign bus.pc        = r_pc;
  assign bus.instr     = r_instr;
  assign bus.pcPlus4   = r_pc_plus4;
  assign bus.valid     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A 256-word
//               instruction memory answers InstrAddr combinationally. A
//               behavioural model tracks the expected pc and IF/ID contents
//               and is compared against the DUT after every clock edge;
//               directed scenarios add literal expectations, followed by a
//               randomized run with occasional asynchronous resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic clk;
  logic rst_n;

  instruction_fetch_if bus ();

  instruction_fetch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory: word index is byte address [9:2].
  logic [31:0] mem [0:255];
  assign bus.InstrIn = mem[bus.InstrAddr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_all();
    chk("pc",        bus.pc,                m_pc);
    chk("instr",     bus.instr,             m_instr);
    chk("pcPlus4",   bus.pcPlus4,           m_pp4);
    chk("valid",     {31'd0, bus.valid},    {31'd0, m_valid});
    chk("InstrAddr", {22'd0, bus.InstrAddr}, {22'd0, m_pc[9:0]});
  endtask

  task automatic model_reset();
    m_pc    = 32'd0;
    m_instr = 32'd0;
    m_pp4   = 32'd0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model with the fetch rules,
  // take the edge and compare 1 time unit after it.
  task automatic step(input logic st, input logic be, input logic [15:0] imm,
                      input logic je, input logic [25:0] jt, input logic [31:0] dp);
    logic [31:0] tgt;
    logic [31:0] n_pc, n_instr, n_pp4;
    logic        n_valid;
    int          off;
    bus.stall         = st;
    bus.branchEn      = be;
    bus.branchImm     = imm;
    bus.jumpEn        = je;
    bus.jumpTarget    = jt;
    bus.decodePcPlus4 = dp;

    off = int'($signed(imm)) * 4;
    if (je)      tgt = {dp[31:28], jt, 2'b00};
    else         tgt = dp + 32'(off);
    tgt[1:0] = 2'b00;

    n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
    if (!rst_n) begin
      n_pc = 0; n_instr = 0; n_pp4 = 0; n_valid = 0;
    end else if (je || be) begin
      n_pc = tgt; n_instr = 32'd0; n_pp4 = m_pc + 32'd4; n_valid = 1'b0;
    end else if (!st) begin
      n_instr = mem[m_pc[9:2]];
      n_pp4   = m_pc + 32'd4;
      n_pc    = m_pc + 32'd4;
      n_valid = 1'b1;
    end

    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h201d3ffc;
    mem[1] = 32'h2008000e;
    mem[2] = 32'h8c090000;

    rst_n             = 1'b0;
    bus.stall         = 1'b0;
    bus.branchEn      = 1'b0;
    bus.branchImm     = 16'h0;
    bus.jumpEn        = 1'b0;
    bus.jumpTarget    = 26'h0;
    bus.decodePcPlus4 = 32'h0;
    model_reset();

    // Reset state.
    #12;
    chk("reset_pc",    bus.pc,    32'h0);
    chk("reset_instr", bus.instr, 32'h0);
    chk("reset_valid", {31'd0, bus.valid}, 32'h0);
    chk("reset_addr",  {22'd0, bus.InstrAddr}, 32'h0);
    rst_n = 1'b1;

    // Two free-running edges after reset.
    idle();
    chk("e1_instr", bus.instr,   32'h201d3ffc);
    chk("e1_pp4",   bus.pcPlus4, 32'h4);
    chk("e1_valid", {31'd0, bus.valid}, 32'h1);
    idle();
    chk("e2_instr", bus.instr,   32'h2008000e);
    chk("e2_pp4",   bus.pcPlus4, 32'h8);
    chk("e2_pc",    bus.pc,      32'h8);

    // Stall for three edges at pc = 8, then release.
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    chk("stall_pc",    bus.pc,      32'h8);
    chk("stall_instr", bus.instr,   32'h2008000e);
    chk("stall_pp4",   bus.pcPlus4, 32'h8);
    chk("stall_valid", {31'd0, bus.valid}, 32'h1);
    idle();
    chk("unstall_pc", bus.pc, 32'd12);

    // Asynchronous reset between edges while stalled at pc = 12.
    bus.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc",    bus.pc,      32'h0);
    chk("async_instr", bus.instr,   32'h0);
    chk("async_pp4",   bus.pcPlus4, 32'h0);
    chk("async_valid", {31'd0, bus.valid}, 32'h0);
    model_reset();
    step(1'b1, 1'b1, 16'h0040, 1'b0, 26'h0, 32'h0);
    #3;
    bus.stall    = 1'b0;
    bus.branchEn = 1'b0;
    rst_n        = 1'b1;
    idle();
    chk("rerun_instr", bus.instr, 32'h201d3ffc);
    chk("rerun_pc",    bus.pc,    32'h4);

    // Taken branch backwards: 0x10 + (-2 * 4) = 0x08.
    step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 32'h10);
    chk("br_pc",    bus.pc,    32'h8);
    chk("br_valid", {31'd0, bus.valid}, 32'h0);
    chk("br_instr", bus.instr, 32'h0);
    idle();
    chk("br_fetch_instr", bus.instr, 32'h8c090000);
    chk("br_fetch_valid", {31'd0, bus.valid}, 32'h1);

    // Jump beats branch and stall.
    step(1'b1, 1'b1, 16'h1234, 1'b1, 26'h000040, 32'h30000004);
    chk("jmp_pc",    bus.pc, 32'h30000100);
    chk("jmp_valid", {31'd0, bus.valid}, 32'h0);

    // Jump to the top word, then wrap on a free edge.
    step(1'b0, 1'b0, 16'h0, 1'b1, 26'h3FFFFFF, 32'hF0000000);
    chk("top_pc", bus.pc, 32'hFFFFFFFC);
    idle();
    chk("wrap_pc",   bus.pc, 32'h0);
    chk("wrap_addr", {22'd0, bus.InstrAddr}, 32'h0);
    chk("wrap_pp4",  bus.pcPlus4, 32'h0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom),
             $urandom_range(0, 1) == 1, 26'($urandom), $urandom);
        #2;
        rst_n = 1'b1;
      end else begin
        step($urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 10,
             16'($urandom),
             $urandom_range(0, 99) < 5,
             26'($urandom),
             $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
